// File: rtl/vram_srv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vram_srv_pkg
//  Description : Shared types and helpers for the VRAM fetch server.
//                srv_state_t - sequencer states
//                WORDS_MAX   - most word reads a single video request needs
//                pair_words  - word reads needed for one little-endian pair
//  Revision    : 1.0 - initial release
// ============================================================================
package vram_srv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    V_ISSUE = 3'd1,
    V_WAIT  = 3'd2,
    C_ISSUE = 3'd3,
    C_WAIT  = 3'd4,
    DONE_V  = 3'd5
  } srv_state_t;

  localparam int WORDS_MAX = 4;

  // An even byte address is served by one word; an odd one straddles two.
  function automatic logic [2:0] pair_words(input logic [31:0] a);
    return ((a % 32'd2) != 32'd0) ? 3'd2 : 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_fetch_server_if.sv
`default_nettype none
// ============================================================================
//  Module      : vram_fetch_server_if
//  Description : Bus bundle around the fetch server.
//                vram_* : video controller request/response (toggle handshake)
//                cpu_*  : byte-wide CPU access (level req, pulse ack)
//                mem_*  : single-port 16-bit video RAM
//                modport slave  - the server side
//                modport master - the environment (video, CPU, RAM)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vram_fetch_server_if #(
  parameter int AW = 19
);
  logic          vram_rd;
  logic [AW-1:0] vram_addr1;
  logic [AW-1:0] vram_addr2;
  logic [15:0]   vram_dout1;
  logic [15:0]   vram_dout2;
  logic          vram_ack;
  logic          vram_overrun;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;

  logic [AW-2:0] mem_addr;
  logic          mem_rd;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [15:0]   mem_din;
  logic [15:0]   mem_q;

  modport slave (
    input  vram_rd, vram_addr1, vram_addr2,
    output vram_dout1, vram_dout2, vram_ack, vram_overrun,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack,
    output mem_addr, mem_rd, mem_we, mem_be, mem_din,
    input  mem_q
  );

  modport master (
    output vram_rd, vram_addr1, vram_addr2,
    input  vram_dout1, vram_dout2, vram_ack, vram_overrun,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack,
    input  mem_addr, mem_rd, mem_we, mem_be, mem_din,
    output mem_q
  );
endinterface
`default_nettype wire

// File: rtl/vram_fetch_server_mem_op_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_op_seq
//  Description : Issues one registered memory strobe per op_start and, for
//                reads, flags op_done in the cycle mem_q becomes valid.
//                op_*  : request from the server sequencer / completion
//                mem_* : RAM strobe, address, byte enables, data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_op_seq #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_start,
  input  logic          op_we,
  input  logic [AW-2:0] op_addr,
  input  logic [1:0]    op_be,
  input  logic [15:0]   op_din,
  output logic          op_done,
  output logic [15:0]   op_q,
  output logic [AW-2:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_q
);
  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          rd_q, rd_d;
  logic          we_q, we_d;
  logic [AW-2:0] addr_q, addr_d;
  logic [1:0]    be_q, be_d;
  logic [15:0]   din_q, din_d;

  // Counter starts at MEM_LAT in the strobe cycle and reaches zero exactly
  // when mem_q is valid, so op_done can be used directly as a capture enable.
  assign op_done = busy_q && (cnt_q == '0);
  assign op_q    = mem_q;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    rd_d   = 1'b0;
    we_d   = 1'b0;
    addr_d = addr_q;
    be_d   = be_q;
    din_d  = din_q;
    if (busy_q && (cnt_q != '0)) cnt_d = cnt_q - CW'(1);
    if (op_done) busy_d = 1'b0;
    if (op_start) begin
      rd_d   = ~op_we;
      we_d   = op_we;
      addr_d = op_addr;
      be_d   = op_be;
      din_d  = op_din;
      busy_d = ~op_we;
      cnt_d  = CW'(MEM_LAT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      rd_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      be_q   <= '0;
      din_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      rd_q   <= rd_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      be_q   <= be_d;
      din_q  <= din_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign mem_we   = we_q;
  assign mem_be   = be_q;
  assign mem_din  = din_q;
endmodule
`default_nettype wire

// File: rtl/vram_fetch_server.sv
`default_nettype none
// ============================================================================
//  Module      : vram_fetch_server
//  Description : Memory-side responder for the video VRAM fetch interface.
//                Detects vram_rd toggles, reads the 2-4 words needed for two
//                little-endian byte pairs, and fills idle slots with CPU
//                byte reads/writes.
//                clk_sys, reset : clock, asynchronous active-high reset
//                bus (slave)    : vram_*, cpu_* and mem_* signal groups
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_fetch_server
  import vram_srv_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 19
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  vram_fetch_server_if.slave    bus
);
  srv_state_t    state_q, state_d;
  logic          armed_q, armed_d, prev_q, prev_d;
  logic          pending_q, pending_d, overrun_q, overrun_d;
  logic [AW-1:0] lat1_q, lat1_d, lat2_q, lat2_d;
  logic [AW-1:0] wa1_q, wa1_d, wa2_q, wa2_d;
  logic [1:0]    widx_q, widx_d;
  logic [15:0]   asm1_q, asm1_d, asm2_q, asm2_d;
  logic [15:0]   dout1_q, dout1_d, dout2_q, dout2_d;
  logic          ack_q, ack_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          cpu_ack_q, cpu_ack_d, cpu_odd_q, cpu_odd_d, cpu_wr_q, cpu_wr_d;

  logic          op_start, op_we, op_done;
  logic [AW-2:0] op_addr;
  logic [1:0]    op_be;
  logic [15:0]   op_din, op_q;
  logic          toggle, consume, in_p1, sub_hi, more;
  logic [2:0]    n1, n_words;
  logic [AW-2:0] m_addr;
  logic          m_rd, m_we;
  logic [1:0]    m_be;
  logic [15:0]   m_din;

  // Word list order: pair1 low word, pair1 high word (odd only), then pair2.
  function automatic logic [AW-2:0] word_addr(input logic [AW-1:0] a1,
                                               input logic [AW-1:0] a2,
                                               input logic [1:0]    idx);
    logic [2:0] p1;
    p1 = pair_words(32'(a1));
    if ({1'b0, idx} < p1) return a1[AW-1:1] + (AW-1)'(idx);
    return a2[AW-1:1] + (({1'b0, idx} == p1 + 3'd1) ? (AW-1)'(1) : '0);
  endfunction

  // Even pair takes the whole word; odd pair takes the high byte of its first
  // word as result low byte and the low byte of its second word as high byte.
  function automatic logic [15:0] place(input logic [15:0] old, input logic odd,
                                        input logic hi, input logic [15:0] q);
    if (!odd) return q;
    if (!hi)  return {old[15:8], q[15:8]};
    return {q[7:0], old[7:0]};
  endfunction

  always_comb begin
    state_d    = state_q;
    armed_d    = 1'b1;
    prev_d     = bus.vram_rd;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    lat1_d     = lat1_q;
    lat2_d     = lat2_q;
    wa1_d      = wa1_q;
    wa2_d      = wa2_q;
    widx_d     = widx_q;
    asm1_d     = asm1_q;
    asm2_d     = asm2_q;
    dout1_d    = dout1_q;
    dout2_d    = dout2_q;
    ack_d      = ack_q;
    cpu_dout_d = cpu_dout_q;
    cpu_ack_d  = 1'b0;
    cpu_odd_d  = cpu_odd_q;
    cpu_wr_d   = cpu_wr_q;
    op_start   = 1'b0;
    op_we      = 1'b0;
    op_addr    = '0;
    op_be      = 2'b11;
    op_din     = '0;

    n1      = pair_words(32'(wa1_q));
    n_words = n1 + pair_words(32'(wa2_q));
    in_p1   = ({1'b0, widx_q} < n1);
    sub_hi  = in_p1 ? widx_q[0] : ({1'b0, widx_q} == n1 + 3'd1);
    more    = (({1'b0, widx_q} + 3'd1) < n_words);

    // The first cycle after reset only records the current level.
    toggle  = armed_q && (bus.vram_rd != prev_q);
    consume = (state_q == IDLE) && pending_q;
    if (toggle) begin
      pending_d = 1'b1;
      lat1_d    = bus.vram_addr1;
      lat2_d    = bus.vram_addr2;
      if (pending_q && !consume) overrun_d = 1'b1;
    end else if (consume) begin
      pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          wa1_d    = lat1_q;
          wa2_d    = lat2_q;
          widx_d   = 2'd0;
          op_start = 1'b1;
          op_addr  = word_addr(lat1_q, lat2_q, 2'd0);
          state_d  = V_ISSUE;
        end else if (bus.cpu_req && !cpu_ack_q) begin
          // cpu_req is still high during the ack cycle; do not re-serve it.
          op_start  = 1'b1;
          op_we     = bus.cpu_we;
          op_addr   = bus.cpu_addr[AW-1:1];
          op_be     = bus.cpu_addr[0] ? 2'b10 : 2'b01;
          op_din    = {bus.cpu_din, bus.cpu_din};
          cpu_odd_d = bus.cpu_addr[0];
          cpu_wr_d  = bus.cpu_we;
          state_d   = C_ISSUE;
        end
      end
      V_ISSUE: state_d = V_WAIT;
      V_WAIT: begin
        if (op_done) begin
          if (in_p1) asm1_d = place(asm1_q, wa1_q[0], sub_hi, op_q);
          else       asm2_d = place(asm2_q, wa2_q[0], sub_hi, op_q);
          if (more) begin
            widx_d   = widx_q + 2'd1;
            op_start = 1'b1;
            op_addr  = word_addr(wa1_q, wa2_q, widx_q + 2'd1);
            state_d  = V_ISSUE;
          end else begin
            state_d = DONE_V;
          end
        end
      end
      DONE_V: begin
        dout1_d = asm1_q;
        dout2_d = asm2_q;
        ack_d   = ~ack_q;
        state_d = IDLE;
      end
      C_ISSUE: begin
        if (cpu_wr_q) begin
          cpu_ack_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = C_WAIT;
        end
      end
      C_WAIT: begin
        if (op_done) begin
          cpu_dout_d = cpu_odd_q ? op_q[15:8] : op_q[7:0];
          cpu_ack_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      prev_q     <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      lat1_q     <= '0;
      lat2_q     <= '0;
      wa1_q      <= '0;
      wa2_q      <= '0;
      widx_q     <= '0;
      asm1_q     <= '0;
      asm2_q     <= '0;
      dout1_q    <= '0;
      dout2_q    <= '0;
      ack_q      <= 1'b0;
      cpu_dout_q <= '0;
      cpu_ack_q  <= 1'b0;
      cpu_odd_q  <= 1'b0;
      cpu_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      lat1_q     <= lat1_d;
      lat2_q     <= lat2_d;
      wa1_q      <= wa1_d;
      wa2_q      <= wa2_d;
      widx_q     <= widx_d;
      asm1_q     <= asm1_d;
      asm2_q     <= asm2_d;
      dout1_q    <= dout1_d;
      dout2_q    <= dout2_d;
      ack_q      <= ack_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_odd_q  <= cpu_odd_d;
      cpu_wr_q   <= cpu_wr_d;
    end
  end

  mem_op_seq #(.MEM_LAT(MEM_LAT), .AW(AW)) u_seq (
    .clk      (clk_sys),
    .rst      (reset),
    .op_start (op_start),
    .op_we    (op_we),
    .op_addr  (op_addr),
    .op_be    (op_be),
    .op_din   (op_din),
    .op_done  (op_done),
    .op_q     (op_q),
    .mem_addr (m_addr),
    .mem_rd   (m_rd),
    .mem_we   (m_we),
    .mem_be   (m_be),
    .mem_din  (m_din),
    .mem_q    (bus.mem_q)
  );

  assign bus.mem_addr     = m_addr;
  assign bus.mem_rd       = m_rd;
  assign bus.mem_we       = m_we;
  assign bus.mem_be       = m_be;
  assign bus.mem_din      = m_din;
  assign bus.vram_dout1   = dout1_q;
  assign bus.vram_dout2   = dout2_q;
  assign bus.vram_ack     = ack_q;
  assign bus.vram_overrun = overrun_q;
  assign bus.cpu_dout     = cpu_dout_q;
  assign bus.cpu_ack      = cpu_ack_q;
endmodule
`default_nettype wire

// File: tb/tb_vram_fetch_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_fetch_server
//  Description : Directed bench for vram_fetch_server with a RAM model and a
//                scoreboard of expected video byte pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_fetch_server;
  localparam int AW      = 19;
  localparam int MEM_LAT = 2;
  localparam int WORDS   = 1 << (AW - 1);

  logic clk;
  logic reset;

  vram_fetch_server_if #(.AW(AW)) bus ();

  vram_fetch_server #(.MEM_LAT(MEM_LAT), .AW(AW)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data appears MEM_LAT cycles after the strobe cycle.
  logic [15:0]   mem [0:WORDS-1];
  logic [AW-2:0] p0_a, p1_a;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_be[0]) mem[bus.mem_addr][7:0]  <= bus.mem_din[7:0];
      if (bus.mem_be[1]) mem[bus.mem_addr][15:8] <= bus.mem_din[15:8];
    end
    p0_a <= bus.mem_addr;
    p1_a <= p0_a;
  end
  assign bus.mem_q = mem[p1_a];

  int checks = 0;
  int errors = 0;
  int rd_count = 0, we_count = 0, ack_count = 0, we_ack_at = 0;
  logic [1:0]  we_be = 2'b00;
  logic        last_ack = 1'b0;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: strobe counting and scoreboard pop on every vram_ack toggle.
  always @(negedge clk) begin
    if (!reset && bus.mem_rd) rd_count++;
    if (!reset && bus.mem_we) begin
      we_count++;
      we_be     = bus.mem_be;
      we_ack_at = ack_count;
    end
    if (reset) begin
      last_ack = bus.vram_ack;
    end else if (bus.vram_ack !== last_ack) begin
      last_ack = bus.vram_ack;
      ack_count++;
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        logic [31:0] e;
        e = sb.pop_front();
        check("vram_dout1", 32'(bus.vram_dout1), 32'(e[31:16]));
        check("vram_dout2", 32'(bus.vram_dout2), 32'(e[15:0]));
      end
    end
  end

  task automatic toggle(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic push, input logic [15:0] e1, input logic [15:0] e2);
    bus.vram_addr1 = a1;
    bus.vram_addr2 = a2;
    bus.vram_rd    = ~bus.vram_rd;
    if (push) sb.push_back({e1, e2});
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    logic prev;
    prev = bus.vram_ack;
    cyc  = 0;
    while (bus.vram_ack === prev && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("ack_toggled", 32'(bus.vram_ack !== prev), 32'd1);
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [7:0] exp);
    int cyc;
    @(posedge clk); #2;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = a;
    cyc = 0;
    while (!bus.cpu_ack && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("cpu_rd_ack", 32'(bus.cpu_ack), 32'd1);
    check("cpu_rd_data", 32'(bus.cpu_dout), 32'(exp));
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    int cyc, rd_base, we_base, ack_base;
    for (int i = 0; i < WORDS; i++) mem[i] = 16'h0000;
    mem[18'h10]    = 16'hBBAA;
    mem[18'h11]    = 16'hDDCC;
    mem[18'h3FFFF] = 16'h1234;
    mem[18'h0]     = 16'h5678;
    mem[18'h20]    = 16'h2211;
    mem[18'h21]    = 16'h4433;

    reset          = 1'b1;
    bus.vram_rd    = 1'b1;
    bus.vram_addr1 = '0;
    bus.vram_addr2 = '0;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_din    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout1", 32'(bus.vram_dout1), 32'd0);
    check("rst_dout2", 32'(bus.vram_dout2), 32'd0);
    check("rst_ack_overrun", 32'({bus.vram_ack, bus.vram_overrun}), 32'd0);
    check("rst_cpu", 32'({bus.cpu_ack, bus.cpu_dout}), 32'd0);
    check("rst_mem", 32'({bus.mem_rd, bus.mem_we, bus.mem_be, bus.mem_addr}), 32'd0);

    // Release with vram_rd high: arming must not create a request.
    @(posedge clk); #2;
    reset   = 1'b0;
    rd_base = rd_count;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("arm_no_rd", 32'(rd_count - rd_base), 32'd0);
    check("arm_no_ack", 32'(bus.vram_ack), 32'd0);

    // Even + odd pair: 1 + 2 word reads.
    @(posedge clk); #2;
    rd_base = rd_count;
    toggle(19'h00020, 19'h00021, 1'b1, 16'hBBAA, 16'hCCBB);
    wait_ack(40, cyc);
    @(posedge clk); @(negedge clk);
    check("eo_rd_count", 32'(rd_count - rd_base), 32'd3);
    check("eo_ack_count", 32'(ack_count), 32'd1);

    // Address wrap, four word reads; must finish inside the sample window.
    @(posedge clk); #2;
    toggle(19'h7FFFF, 19'h00021, 1'b1, 16'h7812, 16'hCCBB);
    wait_ack(40, cyc);
    check("wrap_latency_le16", 32'(cyc <= 16), 32'd1);

    // CPU write one cycle ahead of a video toggle.
    @(posedge clk); #2;
    we_base      = we_count;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 19'h00021;
    bus.cpu_din  = 8'h5A;
    @(posedge clk); #2;
    toggle(19'h00040, 19'h00041, 1'b1, 16'h2211, 16'h3322);
    cyc = 0;
    while (!bus.cpu_ack && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ctn_cpu_ack", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req = 1'b0;
    wait_ack(40, cyc);
    check("ctn_we_count", 32'(we_count - we_base), 32'd1);
    check("ctn_we_be", 32'(we_be), 32'd2);
    check("ctn_we_before_ack", 32'(we_ack_at), 32'd2);

    @(posedge clk); #2;
    toggle(19'h00020, 19'h00020, 1'b1, 16'h5AAA, 16'h5AAA);
    wait_ack(40, cyc);
    cpu_read(19'h00021, 8'h5A);
    cpu_read(19'h00022, 8'hCC);

    // Overrun: second request replaced by the third, two acks only.
    @(posedge clk); #2;
    check("ovr_clear_before", 32'(bus.vram_overrun), 32'd0);
    ack_base = ack_count;
    toggle(19'h00020, 19'h00020, 1'b1, 16'h5AAA, 16'h5AAA);
    repeat (3) @(posedge clk); #2;
    toggle(19'h00022, 19'h00022, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk); #2;
    toggle(19'h00022, 19'h00023, 1'b1, 16'hDDCC, 16'h00DD);
    wait_ack(40, cyc);
    wait_ack(40, cyc);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("ovr_ack_count", 32'(ack_count - ack_base), 32'd2);
    check("ovr_flag", 32'(bus.vram_overrun), 32'd1);

    // Reset while the first word read is in flight.
    @(posedge clk); #2;
    ack_base = ack_count;
    toggle(19'h00020, 19'h00021, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk); #2;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mid_rst_dout1", 32'(bus.vram_dout1), 32'd0);
    check("mid_rst_flags", 32'({bus.vram_ack, bus.vram_overrun, bus.mem_rd}), 32'd0);
    @(posedge clk); #2;
    reset   = 1'b0;
    rd_base = rd_count;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_ack", 32'(ack_count - ack_base), 32'd0);
    check("mid_rst_no_rd", 32'(rd_count - rd_base), 32'd0);

    @(posedge clk); #2;
    toggle(19'h00020, 19'h00022, 1'b1, 16'h5AAA, 16'hDDCC);
    wait_ack(40, cyc);
    @(posedge clk); @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vram_fetch_server.md
Name: vram_fetch_server

Overview:
- Memory-side responder for the video controller's VRAM fetch interface.
- Detects each toggle of vram_rd and latches the two 19-bit byte addresses.
- Reads the needed 16-bit words from single-port video RAM and returns two little-endian byte pairs before the video's sample point (hc[2:0]==4).
- Services byte-wide CPU reads and writes in the remaining memory slots.

Parameters:
- MEM_LAT, 2, clk_sys cycles from a mem_rd strobe to valid mem_q.
- AW, 19, byte-address width; memory holds 2^(AW-1) 16-bit words.

Ports:
- clk_sys  in  1  master clock.
- reset  in  1  asynchronous, active-high reset.
- vram_rd  in  1  request toggle from the video controller.
- vram_addr1  in  AW  byte address of the first pair.
- vram_addr2  in  AW  byte address of the second pair.
- vram_dout1  out  16  {M[a1+1], M[a1]}.
- vram_dout2  out  16  {M[a2+1], M[a2]}.
- vram_ack  out  1  toggles when both douts update.
- vram_overrun  out  1  sticky: a request was replaced before service.
- cpu_req  in  1  CPU access request, level, held until ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU byte address.
- cpu_din  in  8  write data.
- cpu_dout  out  8  read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_addr  out  AW-1  word address.
- mem_rd  out  1  one-cycle read strobe.
- mem_we  out  1  one-cycle write strobe.
- mem_be  out  2  byte enables; bit0 = low byte = even address.
- mem_din  out  16  write data, cpu_din replicated to both bytes.
- mem_q  in  16  read data, valid MEM_LAT cycles after mem_rd.

Behaviour:
- Reset values: all outputs 0; state IDLE; pending 0; armed 0.
- Reset mid-operation aborts everything: no ack is issued and in-flight mem_q is discarded.
- Toggle detection:
  - First cycle after reset: armed<=1 and prev<=vram_rd; no request is generated.
  - Afterwards, vram_rd!=prev sets pending and latches both addresses.
  - A toggle while pending is already set overwrites the latched addresses and sets vram_overrun.
- Byte-pair rule: for byte address a, result = {M[a+1], M[a]}, with a+1 computed modulo 2^AW.
  - Even a: one word read of word a>>1; result = that word.
  - Odd a: word a>>1 supplies the low result byte (its high byte); word ((a>>1)+1) mod 2^(AW-1) supplies the high result byte (its low byte).
  - A video request therefore needs 2-4 word reads.
- FSM states: IDLE, V_ISSUE, V_WAIT, C_ISSUE, C_WAIT, DONE_V.
  - IDLE: pending has priority over cpu_req.
    - pending: clear pending, copy addresses into the working set, go to V_ISSUE.
    - else cpu_req: go to C_ISSUE.
  - V_ISSUE: one read strobe for the next word, then V_WAIT.
  - V_WAIT: count MEM_LAT cycles, capture the byte(s) into the assembly registers, then V_ISSUE if words remain, else DONE_V.
  - DONE_V: update vram_dout1 and vram_dout2 in the same cycle, toggle vram_ack, go to IDLE.
  - A toggle arriving during a sequence is latched only; it is served after DONE_V.
  - C_ISSUE:
    - Write: mem_we with mem_be=2'b01 for even address, 2'b10 for odd; cpu_ack pulses the next cycle; return to IDLE.
    - Read: mem_rd, then C_WAIT.
  - C_WAIT: after MEM_LAT cycles, cpu_dout <= selected byte and cpu_ack pulses; go to IDLE.
  - A CPU access in progress is never preempted; video waits at most MEM_LAT+1 cycles.
- Latency:
  - Toggle to vram_ack, worst case with no CPU op: 1 + 4*(MEM_LAT+1) + 1 = 14 cycles at MEM_LAT=2.
  - Add MEM_LAT+1 for a blocking CPU access.
  - The integrator guarantees at least 16 clk_sys cycles between toggle and sample.
- Outputs hold their values between updates.
- Write data is visible to any later read issued to memory.

Decomposition:
- Package vram_srv_pkg:
  - state enum srv_state_t.
  - localparam WORDS_MAX=4.
  - function pair_words(a), returning the word count.
- Sub-module mem_op_seq: issues one strobe, counts MEM_LAT, asserts op_done with captured mem_q; shared by the video and CPU paths.

Test Plan:
- Memory model: word 0x10=0xBBAA, word 0x11=0xDDCC.
- Even/odd fetch: toggle with addr1=0x00020, addr2=0x00021 -> vram_dout1=0xBBAA, vram_dout2=0xCCBB, vram_ack toggles once, exactly 3 mem_rd strobes.
- Wrap: word 0x3FFFF=0x1234, word 0=0x5678; addr1=0x7FFFF -> vram_dout1=0x7812.
- Reset arming: reset released with vram_rd=1 -> no mem_rd and vram_ack stays 0; a later toggle produces one fetch.
- CPU contention: cpu_req write 0x5A to 0x00021 one cycle before a video toggle -> mem_we with mem_be=2'b10 first; video ack follows; a later fetch of 0x00020 returns 0x5AAA.
- Overrun: two toggles within one sequence, then a third -> second addresses replaced by third, vram_overrun=1, exactly two acks.
- Reset mid-sequence: assert reset during V_WAIT -> outputs 0, no ack toggle, FSM in IDLE after release.
